// File: rtl/packetizer.sv
`default_nettype none
// ============================================================================
//  Module   : packetizer
//  Purpose  : Packs a valid/ready stream of 16-bit words into 48-bit flits
//             {header, data, running XOR checksum}. A packet closes after
//             PKT_LEN words, or early on flush. The tail flit carries header
//             16'hFFFF.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   1   rising-edge clock
//    reset       in   1   asynchronous active-high reset
//    data_in     in  16   payload word
//    data_valid  in   1   data_in is valid
//    data_ready  out  1   block can take a word or a flush this cycle
//    flush       in   1   close the open packet now
//    flitout     out 48   flit to the de-packetizer
//    flit_valid  out  1   flitout is valid
//    flit_ready  in   1   downstream accepts flitout
//    pkt_count   out  8   tail flits emitted, mod 256
//    busy        out  1   packet open or flit pending
// ============================================================================
module packetizer #(
  parameter int         PKT_LEN = 4,
  parameter logic [7:0] SRC_ID  = 8'h01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic        flush,
  output logic [47:0] flitout,
  output logic        flit_valid,
  input  logic        flit_ready,
  output logic [7:0]  pkt_count,
  output logic        busy
);

  localparam logic [15:0] c_TAIL_HDR = 16'hFFFF;
  localparam logic [7:0]  c_LAST_IDX = 8'(PKT_LEN - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_OPEN = 1'b1
  } state_t;

  state_t      r_state, w_state_next;
  logic [7:0]  r_idx, w_idx_next;
  logic [15:0] r_csum, w_csum_next;
  logic [7:0]  r_pkt_count, w_pkt_next;
  logic [47:0] r_flit, w_flit_next;
  logic        r_flit_valid, w_flit_valid_next;

  logic        w_close_empty;
  logic        w_load;
  logic        w_tail;
  logic [15:0] w_csum_data;

  // The output register is free when empty or being drained this edge.
  assign data_ready    = !r_flit_valid || flit_ready;
  // A bare flush only means something while a packet is open.
  assign w_close_empty = flush && !data_valid && (r_state == S_OPEN);
  assign w_load        = (data_valid || w_close_empty) && data_ready;
  assign w_tail        = (r_idx == c_LAST_IDX) || flush;
  assign w_csum_data   = r_csum ^ data_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_idx        <= 8'h00;
      r_csum       <= 16'h0000;
      r_pkt_count  <= 8'h00;
      r_flit       <= 48'h0;
      r_flit_valid <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_idx        <= w_idx_next;
      r_csum       <= w_csum_next;
      r_pkt_count  <= w_pkt_next;
      r_flit       <= w_flit_next;
      r_flit_valid <= w_flit_valid_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_idx_next        = r_idx;
    w_csum_next       = r_csum;
    w_pkt_next        = r_pkt_count;
    w_flit_next       = r_flit;
    w_flit_valid_next = r_flit_valid;

    if (w_load) begin
      w_flit_valid_next = 1'b1;
      if (data_valid) begin
        if (w_tail) begin
          w_flit_next  = {c_TAIL_HDR, data_in, w_csum_data};
          w_state_next = S_IDLE;
          w_idx_next   = 8'h00;
          w_csum_next  = 16'h0000;
          w_pkt_next   = r_pkt_count + 8'd1;
        end else begin
          w_flit_next  = {SRC_ID, r_idx, data_in, w_csum_data};
          w_state_next = S_OPEN;
          w_idx_next   = r_idx + 8'd1;
          w_csum_next  = w_csum_data;
        end
      end else begin
        // Empty tail: no data, checksum of the words already sent.
        w_flit_next  = {c_TAIL_HDR, 16'h0000, r_csum};
        w_state_next = S_IDLE;
        w_idx_next   = 8'h00;
        w_csum_next  = 16'h0000;
        w_pkt_next   = r_pkt_count + 8'd1;
      end
    end else if (flit_ready) begin
      w_flit_valid_next = 1'b0;
    end
  end

  assign flitout    = r_flit;
  assign flit_valid = r_flit_valid;
  assign pkt_count  = r_pkt_count;
  assign busy       = (r_state == S_OPEN) || r_flit_valid;

endmodule
`default_nettype wire

// File: tb/tb_packetizer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_packetizer
//  Purpose  : Directed self-checking bench for packetizer (PKT_LEN=4,
//             SRC_ID=8'h01).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_packetizer;

  logic        clk;
  logic        reset;
  logic [15:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic        flush;
  logic [47:0] flitout;
  logic        flit_valid;
  logic        flit_ready;
  logic [7:0]  pkt_count;
  logic        busy;

  int n_tests;
  int n_fail;

  packetizer #(.PKT_LEN(4), .SRC_ID(8'h01)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .flush      (flush),
    .flitout    (flitout),
    .flit_valid (flit_valid),
    .flit_ready (flit_ready),
    .pkt_count  (pkt_count),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one word (optionally with flush) for exactly one edge.
  task automatic send(input logic [15:0] w, input logic f);
    data_in    = w;
    data_valid = 1'b1;
    flush      = f;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic flush_only();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    reset      = 1'b1;
    data_in    = 16'h0;
    data_valid = 1'b0;
    flush      = 1'b0;
    flit_ready = 1'b1;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    check("rst_flitout", flitout, 48'h0);
    check("rst_valid", 48'(flit_valid), 48'h0);
    check("rst_pkt", 48'(pkt_count), 48'h0);
    check("rst_busy", 48'(busy), 48'h0);
    check("rst_ready", 48'(data_ready), 48'h1);
    reset = 1'b0;
    idle_cycle();

    // ---------------- full packet ----------------
    send(16'h1111, 1'b0);
    check("full0", flitout, 48'h0100_1111_1111);
    check("full0_v", 48'(flit_valid), 48'h1);
    check("full0_busy", 48'(busy), 48'h1);
    send(16'h2222, 1'b0);
    check("full1", flitout, 48'h0101_2222_3333);
    send(16'h4444, 1'b0);
    check("full2", flitout, 48'h0102_4444_7777);
    send(16'h8888, 1'b0);
    check("full3", flitout, 48'hFFFF_8888_FFFF);
    check("full_pkt", 48'(pkt_count), 48'h1);
    idle_cycle();
    check("drain_v", 48'(flit_valid), 48'h0);
    check("drain_busy", 48'(busy), 48'h0);

    // ---------------- flush with data ----------------
    send(16'h0003, 1'b0);
    check("fd0", flitout, 48'h0100_0003_0003);
    send(16'h0005, 1'b1);
    check("fd1", flitout, 48'hFFFF_0005_0006);
    check("fd_pkt", 48'(pkt_count), 48'h2);
    send(16'h0007, 1'b0);
    check("fd_next", flitout, 48'h0100_0007_0007);

    // ---------------- flush without data ----------------
    flush_only();
    check("fe0", flitout, 48'hFFFF_0000_0007);
    check("fe0_pkt", 48'(pkt_count), 48'h3);
    send(16'h00AA, 1'b0);
    check("fe1a", flitout, 48'h0100_00AA_00AA);
    flush_only();
    check("fe1b", flitout, 48'hFFFF_0000_00AA);
    check("fe1_pkt", 48'(pkt_count), 48'h4);
    idle_cycle();
    flush_only();
    check("fidle_v", 48'(flit_valid), 48'h0);
    check("fidle_pkt", 48'(pkt_count), 48'h4);
    check("fidle_busy", 48'(busy), 48'h0);

    // ---------------- backpressure ----------------
    flit_ready = 1'b0;
    send(16'h1234, 1'b0);
    check("bp0", flitout, 48'h0100_1234_1234);
    data_in    = 16'h5678;
    data_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", 48'(data_ready), 48'h0);
      @(posedge clk);
      #1;
      check("bp_hold", flitout, 48'h0100_1234_1234);
      check("bp_hold_v", 48'(flit_valid), 48'h1);
    end
    flit_ready = 1'b1;
    #1;
    check("bp_rel_ready", 48'(data_ready), 48'h1);
    @(posedge clk);
    #1;
    check("bp1", flitout, 48'h0101_5678_444C);
    send(16'h9ABC, 1'b0);
    check("bp2", flitout, 48'h0102_9ABC_DEF0);
    send(16'hDEF0, 1'b0);
    check("bp3", flitout, 48'hFFFF_DEF0_0000);
    check("bp_pkt", 48'(pkt_count), 48'h5);
    idle_cycle();

    // ---------------- reset mid-packet ----------------
    send(16'h1111, 1'b0);
    check("mr0", flitout, 48'h0100_1111_1111);
    #2;
    reset = 1'b1;
    #1;
    check("mr_flit", flitout, 48'h0);
    check("mr_v", 48'(flit_valid), 48'h0);
    check("mr_pkt", 48'(pkt_count), 48'h0);
    check("mr_busy", 48'(busy), 48'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(16'h2222, 1'b0);
    check("mr_next", flitout, 48'h0100_2222_2222);

    // ---------------- pkt_count wrap ----------------
    send(16'h0001, 1'b1);
    check("wr_tail", flitout, 48'hFFFF_0001_2223);
    check("wr_pkt1", 48'(pkt_count), 48'h1);
    for (int i = 0; i < 254; i++) send(16'(i), 1'b1);
    check("wr_pkt255", 48'(pkt_count), 48'hFF);
    send(16'h00C3, 1'b1);
    check("wr_single", flitout, 48'hFFFF_00C3_00C3);
    check("wr_pkt0", 48'(pkt_count), 48'h0);
    idle_cycle();
    check("end_busy", 48'(busy), 48'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/packetizer.md
# packetizer

Upstream stage of the flit de-packetizer: accepts a stream of 16-bit data words over a valid/ready handshake and emits 48-bit flits, closing a packet after `PKT_LEN` words or on `flush`. The tail flit carries header `16'hFFFF` in `[47:32]`, which is the packet-end condition the downstream de-packetizer decodes. Data is placed in `[31:16]`, and a running XOR checksum of the packet is placed in `[15:0]`. It has a single-entry registered output with backpressure, a packet FSM, a flit index counter and a packet counter.

## Interface
Parameters:
- `PKT_LEN`, default 4: data flits per full packet, legal range 1..255.
- `SRC_ID`, default `8'h01`: source tag in non-tail headers. Must not be `8'hFF`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `data_in`  in  16  payload word.
- `data_valid`  in  1  `data_in` is valid.
- `data_ready`  out  1  block can take a word or flush this cycle.
- `flush`  in  1  close the open packet now.
- `flitout`  out  48  flit to de-packetizer.
- `flit_valid`  out  1  `flitout` is valid.
- `flit_ready`  in  1  downstream accepts `flitout`.
- `pkt_count`  out  8  number of tail flits emitted, mod 256.
- `busy`  out  1  `(state == OPEN) || flit_valid`.

## Operation
Flit format:
- `[47:32]` on a non-tail flit: `{SRC_ID, idx}`, where `idx` is the 0-based position in the packet.
- `[47:32]` on a tail flit: `16'hFFFF`.
- `[31:16]`: the data word.
- `[15:0]`: XOR of all data words of the packet up to and including this flit.

Output register:
- `data_ready = !flit_valid || flit_ready` (combinational).
- `load = (data_valid || close_empty) && data_ready`.
- `close_empty = flush && !data_valid && state == OPEN`.

FSM states:
- IDLE: no packet open; `idx = 0`, `csum = 0`.
- OPEN: at least one non-tail flit of the packet has been loaded.

Tail determination on a load with `data_valid`:
- The flit is the tail if `idx == PKT_LEN-1` or `flush == 1`.
- Tail: go to IDLE, clear `idx` and `csum`, increment `pkt_count`.
- Non-tail: go to (or stay in) OPEN, increment `idx`, set `csum ^= data_in`.

`close_empty` (flush with no data while OPEN):
- Loads a tail flit with data `16'h0000` and checksum equal to the current `csum`.
- Go to IDLE and increment `pkt_count`.

Other flush and counter rules:
- `flush` in IDLE with no data: ignored, no flit emitted.
- `flush` when `data_ready = 0`: not consumed; the source must hold it.
- `PKT_LEN = 1`: every flit is a tail, and the FSM never leaves IDLE.
- `pkt_count` wraps 255 -> 0.

Output behaviour:
- When `flit_ready` is seen while `flit_valid` is high and no new load occurs, `flit_valid` falls next cycle.
- While `flit_valid && !flit_ready`, `flitout` is held stable.

## Timing
- Reset values: `flitout = 48'h0`, `flit_valid = 0`, `pkt_count = 0`, `busy = 0`, `state = IDLE`, `idx = 0`, `csum = 0`.
  - `data_ready` is 1 during and after reset, since it derives from `flit_valid = 0`.
- Latency: a word accepted at edge N appears on `flitout` with `flit_valid = 1` after edge N (one register stage).
- Throughput: 1 flit per cycle with `flit_ready` held high; a load and an output drain may happen on the same edge.
- Backpressure: with `flit_ready = 0` and `flit_valid = 1`, `data_ready = 0` and no state changes.
- Reset asserted mid-packet: the open packet is discarded and no tail is emitted. After release, the next word starts at `idx = 0` with `csum = 0`.

## Test plan
- **Full packet:** `PKT_LEN = 4`, `SRC_ID = 01`, words `1111, 2222, 4444, 8888`, `flit_ready = 1`.
  - Headers `0100, 0101, 0102, FFFF`.
  - Checksums `1111, 3333, 7777, FFFF`.
  - `pkt_count = 1`.
- **Flush with data:** flush together with the 2nd word `0005` after `0003`.
  - Flits `{0100, 0003, 0003}`, then `{FFFF, 0005, 0006}`.
  - Next word starts at header `0100`.
- **Flush without data while OPEN:** after one word `00AA`, assert `flush` alone.
  - Tail flit `{FFFF, 0000, 00AA}`.
  - `flush` asserted in IDLE produces no flit.
- **Backpressure:** hold `flit_ready = 0` for 3 cycles with `data_valid = 1`.
  - `data_ready = 0` and `flitout` stable during the stall.
  - On release, one flit per cycle with no word lost or duplicated.
- **Reset and wrap:** assert `reset` mid-packet.
  - All outputs return to reset values in the same cycle, and the next packet starts at `idx = 0`.
  - 256 packets wrap `pkt_count` back to 0.
